hc161_seq_ctrl: RTL and testbench
=================================

// Module: hc161_seq_ctrl
// PURPOSE
//  Sequencer for one external HC161 4-bit sync counter. Drives its PE_n/D/CEP_n/CET_n/MR_n
//  pins so that it becomes a programmable interval timer (one-shot or N-period periodic).
//  Watches Q/TC coming back from the counter. Both blocks run on the same clock CP.
//  Period = 16 - preset cycles. Reload is gapless.
// PARAMETERS
//  REP_W  8  width of reps / rep_cnt (number of periods in periodic mode)
// PORTS
//  CP        in   1      clock; rising edge; shared with HC161
//  MR        in   1      reset; asynchronous; active-high
//  start     in   1      request a run; level-sampled in IDLE only
//  stop      in   1      abort the current run
//  periodic  in   1      1 = periodic, 0 = one-shot; latched on start
//  preset    in   4      counter load value; latched on start
//  reps      in   REP_W  number of periods (0 = run until stop); latched on start
//  Q_i       in   4      HC161 Q
//  TC_i      in   1      HC161 TC
//  PE_n      out  1      HC161 parallel enable (load when 0)
//  D         out  4      HC161 data; equals the latched preset
//  CEP_n     out  1      HC161 count-enable P
//  CET_n     out  1      HC161 count-enable T
//  MR_n_o    out  1      HC161 master reset (active-low)
//  busy      out  1      state != IDLE
//  tick      out  1      1-cycle pulse, once per period
//  done      out  1      1-cycle pulse when the run finishes normally
//  rep_cnt   out  REP_W  completed periods in the current run
// BEHAVIOUR
//  All outputs are registered except busy, which is decoded from state.
//  Reset (MR=1, async): state=IDLE, PE_n=1, CEP_n=1, CET_n=1, D=0, MR_n_o=0, tick=0,
//   done=0, rep_cnt=0. MR_n_o rises at the first CP edge after MR falls.
//   MR in mid-run aborts immediately, with no done pulse.
//  States: IDLE, LOAD, RUN, DONE, ABORT.
//  IDLE:
//   - Counter pins idle (PE_n=1, CEP_n=1, CET_n=1).
//   - start=1 and stop=0 -> LOAD. Latch preset into D; latch periodic and reps; clear rep_cnt.
//   - start=1 and stop=1 in the same cycle: stop wins, stay in IDLE.
//  LOAD:
//   - PE_n=0 for exactly 1 cycle; the counter loads preset at the edge that leaves LOAD.
//   - Next state is RUN, entered with CEP_n=CET_n=0.
//  RUN, arming:
//   - Arm condition is Q_i==14. Or, if preset==15, arming happens at the LOAD->RUN edge.
//   - last = !periodic | (reps!=0 & rep_cnt==reps-1).
//   - On arm with last=0: register PE_n=0 for the next cycle, so the counter reloads instead of wrapping.
//   - On arm with last=1: register CEP_n=1 for the next cycle, so the counter holds at 15.
//     CET_n stays 0, so TC still asserts.
//   - preset=15 and last=0: PE_n stays 0 for the whole of RUN; a tick occurs every cycle.
//  RUN, terminal count (TC_i sampled 1 at an edge):
//   - tick=1 and rep_cnt+1 in the next cycle; rep_cnt wraps at 2^REP_W.
//   - If last: go to DONE.
//  DONE: lasts 1 cycle. done=1, CEP_n=1, CET_n=1, PE_n=1. Q holds 15. Then IDLE.
//  ABORT:
//   - Entered when stop=1 in LOAD or RUN; stop beats a TC in the same cycle.
//   - Lasts 1 cycle: MR_n_o=0, CEP_n=1, CET_n=1, PE_n=1, no tick, no done. Then IDLE.
//  start while busy is ignored.
//  Latency, start edge k: load at edge k+1; first TC sampled at edge k+1+(16-preset).
// TESTING
//  1. MR pulse mid-RUN -> all outputs take their reset values immediately; busy=0; MR_n_o=0
//     until the first edge after release.
//  2. One-shot, preset=10, start at edge k -> PE_n=0 in cycle k..k+1; Q runs 10..15;
//     tick and done high in cycle k+7; Q holds 15; busy=0 from edge k+8.
//  3. Periodic, preset=12, reps=3 -> ticks every 4 cycles with Q 12,13,14,15,12,... and no gap;
//     done with the 3rd tick; rep_cnt=3; Q stays 15.
//  4. Periodic, preset=15, reps=0 -> tick every cycle while in RUN; stop -> ABORT with
//     MR_n_o=0 for 1 cycle; Q=0; no done pulse.
//  5. stop in the same cycle as TC_i=1 -> ABORT wins, no tick; start while busy -> ignored;
//     start and stop together in IDLE -> stay in IDLE.
//  6. Periodic, reps=0, REP_W=2, preset=14 -> rep_cnt wraps 3->0; run continues.

Source files
------------

// File: rtl/hc161_seq_ctrl.sv
// hc161_seq_ctrl: sequencer that turns one external HC161 4-bit synchronous
// counter into a programmable interval timer (one-shot or N-period periodic).
// The period is 16 - preset cycles. Reloads are gapless: the counter is loaded
// directly at its terminal count instead of wrapping through 0.
module hc161_seq_ctrl #(
  parameter int REP_W = 8
) (
  input  logic             CP,
  input  logic             MR,
  input  logic             start,
  input  logic             stop,
  input  logic             periodic,
  input  logic [3:0]       preset,
  input  logic [REP_W-1:0] reps,
  input  logic [3:0]       Q_i,
  input  logic             TC_i,
  output logic             PE_n,
  output logic [3:0]       D,
  output logic             CEP_n,
  output logic             CET_n,
  output logic             MR_n_o,
  output logic             busy,
  output logic             tick,
  output logic             done,
  output logic [REP_W-1:0] rep_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE,
    S_ABORT
  } state_t;

  localparam logic [REP_W-1:0] ONE = REP_W'(1);

  state_t           r_state;
  logic             r_periodic;
  logic [REP_W-1:0] r_reps;
  logic [REP_W-1:0] r_rep_cnt;
  logic [3:0]       r_d;
  logic             r_pe_n;
  logic             r_cep_n;
  logic             r_cet_n;
  logic             r_mr_n;
  logic             r_tick;
  logic             r_done;

  logic [REP_W-1:0] w_reps_m1;
  logic [REP_W-1:0] w_rep_cnt_inc;
  logic             w_last;
  logic             w_last_next;
  logic             w_preset_max;
  logic             w_abort;

  // The current period is the last one of the run.
  assign w_reps_m1     = r_reps - ONE;
  assign w_rep_cnt_inc = r_rep_cnt + ONE;
  assign w_last        = !r_periodic || ((r_reps != '0) && (r_rep_cnt == w_reps_m1));
  // Same test, evaluated for the period that starts after a terminal count.
  assign w_last_next   = !r_periodic || ((r_reps != '0) && (w_rep_cnt_inc == w_reps_m1));
  // With preset 15 every period is one cycle long, so arming cannot wait for Q==14.
  assign w_preset_max  = (r_d == 4'hF);
  // stop aborts a run in LOAD or RUN and beats a coincident terminal count.
  assign w_abort       = stop && ((r_state == S_LOAD) || (r_state == S_RUN));

  // Sequencer FSM with registered counter-pin, tick, done and rep_cnt outputs.
  // NOTE: all state here uses non-blocking assignments so every register samples
  // pre-edge values, exactly like the HC161 sitting on the same clock.
  always_ff @(posedge CP or posedge MR) begin
    if (MR) begin
      r_state    <= S_IDLE;
      r_periodic <= 1'b0;
      r_reps     <= '0;
      r_rep_cnt  <= '0;
      r_d        <= 4'd0;
      r_pe_n     <= 1'b1;
      r_cep_n    <= 1'b1;
      r_cet_n    <= 1'b1;
      r_mr_n     <= 1'b0;
      r_tick     <= 1'b0;
      r_done     <= 1'b0;
    end else if (w_abort) begin
      r_state <= S_ABORT;
      r_pe_n  <= 1'b1;
      r_cep_n <= 1'b1;
      r_cet_n <= 1'b1;
      r_mr_n  <= 1'b0;
      r_tick  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_pe_n  <= 1'b1;
          r_cep_n <= 1'b1;
          r_cet_n <= 1'b1;
          r_mr_n  <= 1'b1;
          r_tick  <= 1'b0;
          r_done  <= 1'b0;
          if (start && !stop) begin
            r_state    <= S_LOAD;
            r_d        <= preset;
            r_periodic <= periodic;
            r_reps     <= reps;
            r_rep_cnt  <= '0;
            r_pe_n     <= 1'b0;
          end
        end

        S_LOAD: begin
          // The counter loads preset at this edge; counting starts next cycle.
          r_state <= S_RUN;
          r_cep_n <= 1'b0;
          r_cet_n <= 1'b0;
          r_pe_n  <= 1'b1;
          if (w_preset_max) begin
            if (w_last) r_cep_n <= 1'b1;
            else        r_pe_n  <= 1'b0;
          end
        end

        S_RUN: begin
          r_tick <= 1'b0;
          if (TC_i) begin
            r_tick    <= 1'b1;
            r_rep_cnt <= w_rep_cnt_inc;
            if (w_last) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_pe_n  <= 1'b1;
              r_cep_n <= 1'b1;
              r_cet_n <= 1'b1;
            end else if (w_preset_max) begin
              // Re-arm immediately for the next one-cycle period.
              if (w_last_next) begin
                r_pe_n  <= 1'b1;
                r_cep_n <= 1'b1;
              end else begin
                r_pe_n  <= 1'b0;
              end
            end else begin
              r_pe_n <= 1'b1;
            end
          end else if (Q_i == 4'd14) begin
            // Arm one cycle ahead: reload instead of wrapping, or hold at 15.
            if (w_last) r_cep_n <= 1'b1;
            else        r_pe_n  <= 1'b0;
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
          r_tick  <= 1'b0;
          r_done  <= 1'b0;
        end

        S_ABORT: begin
          r_state <= S_IDLE;
          r_mr_n  <= 1'b1;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign PE_n    = r_pe_n;
  assign D       = r_d;
  assign CEP_n   = r_cep_n;
  assign CET_n   = r_cet_n;
  assign MR_n_o  = r_mr_n;
  assign tick    = r_tick;
  assign done    = r_done;
  assign rep_cnt = r_rep_cnt;
  assign busy    = (r_state != S_IDLE);

endmodule

// File: tb/tb_hc161_seq_ctrl.sv
// tb_hc161_seq_ctrl: directed bench for hc161_seq_ctrl with a behavioural
// HC161 counter closing the loop. REP_W is 2 so rep_cnt wrap is reachable.
module tb_hc161_seq_ctrl;

  localparam int REP_W = 2;

  logic             CP = 1'b0;
  logic             MR;
  logic             start;
  logic             stop;
  logic             periodic;
  logic [3:0]       preset;
  logic [REP_W-1:0] reps;
  logic [3:0]       q;
  logic             tc;
  logic             PE_n;
  logic [3:0]       D;
  logic             CEP_n;
  logic             CET_n;
  logic             MR_n_o;
  logic             busy;
  logic             tick;
  logic             done;
  logic [REP_W-1:0] rep_cnt;

  int checks = 0;
  int errors = 0;

  // One-shot, preset 10: cycles k+1 .. k+8
  logic [3:0] t2_q    [8] = '{4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15, 4'd15, 4'd15};
  logic       t2_tick [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic       t2_cep  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  logic       t2_busy [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  // Periodic, preset 12, reps 3: cycles k+1 .. k+14
  logic [3:0] t3_q    [14] = '{4'd12, 4'd13, 4'd14, 4'd15, 4'd12, 4'd13, 4'd14,
                               4'd15, 4'd12, 4'd13, 4'd14, 4'd15, 4'd15, 4'd15};
  logic       t3_tick [14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                               1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic       t3_pe   [14] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1,
                               1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  logic [1:0] t3_rep  [14] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1,
                               2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3};

  // Periodic, preset 14, reps 0: cycles k+1 .. k+11
  logic [3:0] t6_q    [11] = '{4'd14, 4'd15, 4'd14, 4'd15, 4'd14, 4'd15,
                               4'd14, 4'd15, 4'd14, 4'd15, 4'd14};
  logic       t6_tick [11] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0,
                               1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [1:0] t6_rep  [11] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2,
                               2'd3, 2'd3, 2'd0, 2'd0, 2'd1};

  hc161_seq_ctrl #(.REP_W(REP_W)) dut (
    .CP       (CP),
    .MR       (MR),
    .start    (start),
    .stop     (stop),
    .periodic (periodic),
    .preset   (preset),
    .reps     (reps),
    .Q_i      (q),
    .TC_i     (tc),
    .PE_n     (PE_n),
    .D        (D),
    .CEP_n    (CEP_n),
    .CET_n    (CET_n),
    .MR_n_o   (MR_n_o),
    .busy     (busy),
    .tick     (tick),
    .done     (done),
    .rep_cnt  (rep_cnt)
  );

  always #5 CP = ~CP;

  // Behavioural HC161: async master reset, load beats count, TC gated by CET.
  always @(posedge CP or negedge MR_n_o) begin
    if (!MR_n_o)              q <= 4'd0;
    else if (!PE_n)           q <= D;
    else if (!CEP_n && !CET_n) q <= q + 4'd1;
  end
  assign tc = !CET_n && (q == 4'hF);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; sample and drive 1 ns after it.
  task automatic step();
    @(posedge CP);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " busy"},    32'(busy),    32'd0);
    check({tag, " PE_n"},    32'(PE_n),    32'd1);
    check({tag, " CEP_n"},   32'(CEP_n),   32'd1);
    check({tag, " CET_n"},   32'(CET_n),   32'd1);
    check({tag, " D"},       32'(D),       32'd0);
    check({tag, " MR_n_o"},  32'(MR_n_o),  32'd0);
    check({tag, " tick"},    32'(tick),    32'd0);
    check({tag, " done"},    32'(done),    32'd0);
    check({tag, " rep_cnt"}, 32'(rep_cnt), 32'd0);
    check({tag, " Q"},       32'(q),       32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    MR = 1'b1; start = 1'b0; stop = 1'b0; periodic = 1'b0; preset = 4'd0; reps = '0;
    step();
    step();
    check_reset_vals("reset");
    MR = 1'b0;
    #1;
    check("mr release MR_n_o before edge", 32'(MR_n_o), 32'd0);
    step();
    check("mr release MR_n_o after edge", 32'(MR_n_o), 32'd1);
    check("mr release busy", 32'(busy), 32'd0);

    // One-shot, preset 10
    start = 1'b1; periodic = 1'b0; preset = 4'd10; reps = '0;
    step();
    start = 1'b0;
    check("t2 load busy", 32'(busy), 32'd1);
    check("t2 load PE_n", 32'(PE_n), 32'd0);
    check("t2 load D",    32'(D),    32'd10);
    for (int i = 0; i < 8; i++) begin
      step();
      check($sformatf("t2 Q[%0d]", i),     32'(q),     32'(t2_q[i]));
      check($sformatf("t2 tick[%0d]", i),  32'(tick),  32'(t2_tick[i]));
      check($sformatf("t2 done[%0d]", i),  32'(done),  32'(t2_tick[i]));
      check($sformatf("t2 CEP_n[%0d]", i), 32'(CEP_n), 32'(t2_cep[i]));
      check($sformatf("t2 busy[%0d]", i),  32'(busy),  32'(t2_busy[i]));
      check($sformatf("t2 PE_n[%0d]", i),  32'(PE_n),  32'd1);
    end
    check("t2 rep_cnt", 32'(rep_cnt), 32'd1);

    // Periodic, preset 12, reps 3
    start = 1'b1; periodic = 1'b1; preset = 4'd12; reps = 2'd3;
    step();
    start = 1'b0;
    check("t3 load PE_n",    32'(PE_n),    32'd0);
    check("t3 load rep_cnt", 32'(rep_cnt), 32'd0);
    for (int i = 0; i < 14; i++) begin
      step();
      check($sformatf("t3 Q[%0d]", i),       32'(q),       32'(t3_q[i]));
      check($sformatf("t3 tick[%0d]", i),    32'(tick),    32'(t3_tick[i]));
      check($sformatf("t3 PE_n[%0d]", i),    32'(PE_n),    32'(t3_pe[i]));
      check($sformatf("t3 rep_cnt[%0d]", i), 32'(rep_cnt), 32'(t3_rep[i]));
      check($sformatf("t3 done[%0d]", i),    32'(done),    32'(i == 12));
      if (i == 11) check("t3 hold CEP_n", 32'(CEP_n), 32'd1);
    end
    check("t3 end busy", 32'(busy), 32'd0);

    // Periodic, preset 15, reps 0, then stop
    start = 1'b1; periodic = 1'b1; preset = 4'd15; reps = 2'd0;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("t4 Q[%0d]", i),       32'(q),       32'd15);
      check($sformatf("t4 PE_n[%0d]", i),    32'(PE_n),    32'd0);
      check($sformatf("t4 tick[%0d]", i),    32'(tick),    32'(i != 0));
      check($sformatf("t4 rep_cnt[%0d]", i), 32'(rep_cnt), 32'((i) % 4));
      check($sformatf("t4 done[%0d]", i),    32'(done),    32'd0);
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("t4 abort MR_n_o",  32'(MR_n_o),  32'd0);
    check("t4 abort Q",       32'(q),       32'd0);
    check("t4 abort tick",    32'(tick),    32'd0);
    check("t4 abort done",    32'(done),    32'd0);
    check("t4 abort busy",    32'(busy),    32'd1);
    check("t4 abort CEP_n",   32'(CEP_n),   32'd1);
    check("t4 abort rep_cnt", 32'(rep_cnt), 32'd0);
    step();
    check("t4 idle MR_n_o", 32'(MR_n_o), 32'd1);
    check("t4 idle busy",   32'(busy),   32'd0);
    check("t4 idle done",   32'(done),   32'd0);
    check("t4 idle Q",      32'(q),      32'd0);

    // stop vs TC, start while busy, start+stop in IDLE
    start = 1'b1; periodic = 1'b1; preset = 4'd13; reps = 2'd0;
    step();
    preset = 4'd5;
    step();
    check("t5 Q=13", 32'(q), 32'd13);
    step();
    check("t5 busy start ignored Q", 32'(q), 32'd14);
    check("t5 busy start ignored D", 32'(D), 32'd13);
    check("t5 busy start ignored PE_n", 32'(PE_n), 32'd1);
    step();
    start = 1'b0;
    check("t5 pre-stop Q",  32'(q),  32'd15);
    check("t5 pre-stop TC", 32'(tc), 32'd1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("t5 stop beats TC tick",    32'(tick),    32'd0);
    check("t5 stop beats TC MR_n_o",  32'(MR_n_o),  32'd0);
    check("t5 stop beats TC rep_cnt", 32'(rep_cnt), 32'd0);
    check("t5 stop beats TC done",    32'(done),    32'd0);
    step();
    check("t5 back idle", 32'(busy), 32'd0);
    start = 1'b1; stop = 1'b1; preset = 4'd3;
    step();
    check("t5 start+stop busy", 32'(busy), 32'd0);
    check("t5 start+stop PE_n", 32'(PE_n), 32'd1);
    check("t5 start+stop D",    32'(D),    32'd13);
    start = 1'b0; stop = 1'b0;
    step();
    check("t5 still idle", 32'(busy), 32'd0);

    // Periodic, preset 14, reps 0: rep_cnt wraps 3 -> 0
    start = 1'b1; periodic = 1'b1; preset = 4'd14; reps = 2'd0;
    step();
    start = 1'b0;
    for (int i = 0; i < 11; i++) begin
      step();
      check($sformatf("t6 Q[%0d]", i),       32'(q),       32'(t6_q[i]));
      check($sformatf("t6 tick[%0d]", i),    32'(tick),    32'(t6_tick[i]));
      check($sformatf("t6 rep_cnt[%0d]", i), 32'(rep_cnt), 32'(t6_rep[i]));
      check($sformatf("t6 busy[%0d]", i),    32'(busy),    32'd1);
    end

    // MR pulse mid-run: immediate reset without a clock edge
    MR = 1'b1;
    #1;
    check_reset_vals("t1 mid-run");
    #2;
    MR = 1'b0;
    #1;
    check("t1 MR_n_o held low after release", 32'(MR_n_o), 32'd0);
    step();
    check("t1 MR_n_o after edge", 32'(MR_n_o), 32'd1);
    check("t1 busy after edge",   32'(busy),   32'd0);
    check("t1 Q after edge",      32'(q),      32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
